// File: rtl/spec_rat_recovery_ctrl_pkg.sv
// Shared ROB / rename constants and types for speculative RAT recovery.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package spec_rat_recovery_ctrl_pkg;

    // ROB holds 2**ROB_IDX_W = 64 entries; a pointer carries one extra wrap bit.
    localparam int ROB_IDX_W = 6;
    localparam int PTR_W     = ROB_IDX_W + 1;
    localparam int PREG_W    = 6;
    localparam int LREG_W    = 5;

    // Encodings are shared with the ROB and spec RAT, keep them stable.
    typedef enum logic [1:0] {
        ROB_STATE_IDLE     = 2'b00,
        ROB_STATE_ROLLBACK = 2'b01,
        ROB_STATE_WALK     = 2'b10
    } rob_state_e;

    typedef logic [PTR_W-1:0]  rob_ptr_t;
    typedef logic [PREG_W-1:0] preg_t;
    typedef logic [LREG_W-1:0] lreg_t;

    // Strip the wrap bit to get the physical ROB slot.
    function automatic logic [ROB_IDX_W-1:0] rob_idx(input rob_ptr_t ptr);
        return ptr[ROB_IDX_W-1:0];
    endfunction

endpackage

// File: rtl/spec_rat_recovery_ctrl_rob_ptr_dist.sv
// Wrap-aware ROB pointer distance from a base, plus "closer to base than limit" compare.
// Latency: purely combinational.
// Backpressure: none.
module spec_rat_recovery_ctrl_rob_ptr_dist
    import spec_rat_recovery_ctrl_pkg::*;
(
    input  logic [PTR_W-1:0] i_ptr,
    input  logic [PTR_W-1:0] i_base,
    input  logic [PTR_W-1:0] i_lim,
    output logic [PTR_W-1:0] o_dist,
    output logic             o_older
);

    logic [PTR_W-1:0] w_lim_dist;

    // Modular subtraction makes the wrap bit take care of crossing the ROB end.
    assign o_dist     = i_ptr - i_base;
    assign w_lim_dist = i_lim - i_base;
    assign o_older    = (o_dist < w_lim_dist);

endmodule

// File: rtl/spec_rat_recovery_ctrl.sv
// Spec RAT recovery sequencer: one ROLLBACK cycle, then replays surviving ROB entries 2/cycle.
// Latency: flush -> ROLLBACK next cycle; walk outputs combinational from ROB read data.
// Backpressure: holds rn_stall while busy; optional perf counters under RECOVERY_PERF_CNT_EN.
module spec_rat_recovery_ctrl
    import spec_rat_recovery_ctrl_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 flush_valid,
    input  logic [PTR_W-1:0]     flush_ptr,
    input  logic                 flush_incl_self,
    input  logic [PTR_W-1:0]     rob_head_ptr,
    output logic [ROB_IDX_W-1:0] walk_rd_addr0,
    output logic [ROB_IDX_W-1:0] walk_rd_addr1,
    input  logic                 walk_rd_need_to_wb0,
    input  logic                 walk_rd_need_to_wb1,
    input  logic [LREG_W-1:0]    walk_rd_lrd0,
    input  logic [LREG_W-1:0]    walk_rd_lrd1,
    input  logic [PREG_W-1:0]    walk_rd_prd0,
    input  logic [PREG_W-1:0]    walk_rd_prd1,
    output logic [1:0]           rob_state,
    output logic                 walking_valid0,
    output logic                 walking_valid1,
    output logic [LREG_W-1:0]    walking_lrd0,
    output logic [LREG_W-1:0]    walking_lrd1,
    output logic [PREG_W-1:0]    walking_prd0,
    output logic [PREG_W-1:0]    walking_prd1,
    output logic                 tail_restore_valid,
    output logic [PTR_W-1:0]     tail_restore_ptr,
    output logic                 rn_stall,
    output logic                 recovery_done
`ifdef RECOVERY_PERF_CNT_EN
    ,
    output logic [31:0]          perf_flush_cnt,
    output logic [31:0]          perf_recovery_cycles
`endif
);

    rob_state_e       r_state;
    rob_state_e       w_state_nxt;
    logic [PTR_W-1:0] r_walk_ptr;
    logic [PTR_W-1:0] r_end_ptr;
    logic [PTR_W-1:0] r_head_lat;
    logic             r_tail_vld;
    logic [PTR_W-1:0] w_walk_nxt;
    logic [PTR_W-1:0] w_remaining;
    logic             w_last_walk;
    logic [PTR_W-1:0] w_head_sel;
    logic [PTR_W-1:0] w_flush_dist;
    logic             w_flush_older;
    logic [PTR_W-1:0] w_end_nxt;
    logic             w_flush_acc;
    logic             w_slot0;
    logic             w_slot1;
    logic             w_in_walk;

    // Entries left to replay; "older than walk+3" means at most two remain (final cycle).
    spec_rat_recovery_ctrl_rob_ptr_dist u_remaining (
        .i_ptr   (r_end_ptr),
        .i_base  (r_walk_ptr),
        .i_lim   (r_walk_ptr + PTR_W'(3)),
        .o_dist  (w_remaining),
        .o_older (w_last_walk)
    );

    // Flush age relative to the head: a restart must land strictly before the current boundary.
    assign w_head_sel = (r_state == ROB_STATE_IDLE) ? rob_head_ptr : r_head_lat;

    spec_rat_recovery_ctrl_rob_ptr_dist u_flush_age (
        .i_ptr   (flush_ptr),
        .i_base  (w_head_sel),
        .i_lim   (r_end_ptr - PTR_W'(1)),
        .o_dist  (w_flush_dist),
        .o_older (w_flush_older)
    );

    // New boundary rebuilt from the head-relative distance; same as flush_ptr + incl_self.
    assign w_end_nxt   = w_head_sel + w_flush_dist + PTR_W'(flush_incl_self);
    assign w_flush_acc = flush_valid && ((r_state == ROB_STATE_IDLE) || w_flush_older);
    assign w_in_walk   = (r_state == ROB_STATE_WALK);

    // Next-state, walk-slot activity and done pulse; an accepted flush overrides everything.
    always_comb begin
        w_state_nxt   = r_state;
        w_walk_nxt    = r_walk_ptr;
        w_slot0       = 1'b0;
        w_slot1       = 1'b0;
        recovery_done = 1'b0;
        case (r_state)
            ROB_STATE_IDLE: begin
                w_state_nxt = ROB_STATE_IDLE;
            end
            ROB_STATE_ROLLBACK: begin
                if (w_remaining == '0) begin
                    w_state_nxt   = ROB_STATE_IDLE;
                    recovery_done = 1'b1;
                end else begin
                    w_state_nxt = ROB_STATE_WALK;
                end
            end
            ROB_STATE_WALK: begin
                w_slot0    = (w_remaining != '0);
                w_slot1    = (w_remaining >= PTR_W'(2));
                w_walk_nxt = r_walk_ptr + PTR_W'(w_slot0) + PTR_W'(w_slot1);
                if (w_last_walk) begin
                    w_state_nxt   = ROB_STATE_IDLE;
                    recovery_done = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ROB_STATE_IDLE;
            end
        endcase
        if (w_flush_acc) begin
            w_state_nxt   = ROB_STATE_ROLLBACK;
            w_walk_nxt    = w_head_sel;
            recovery_done = 1'b0;
        end
    end

    // Recovery state, walk/end pointers, latched head and the tail-restore pulse.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ROB_STATE_IDLE;
            r_walk_ptr <= '0;
            r_end_ptr  <= '0;
            r_head_lat <= '0;
            r_tail_vld <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_walk_ptr <= w_walk_nxt;
            r_tail_vld <= w_flush_acc;
            if (w_flush_acc) begin
                r_end_ptr <= w_end_nxt;
            end
            if (w_flush_acc && (r_state == ROB_STATE_IDLE)) begin
                r_head_lat <= rob_head_ptr;
            end
        end
    end

    assign rob_state          = r_state;
    assign rn_stall           = (r_state != ROB_STATE_IDLE);
    assign tail_restore_valid = r_tail_vld;
    assign tail_restore_ptr   = r_end_ptr;

    // ROB read addresses only driven while walking; slot1 wraps within the ROB.
    assign walk_rd_addr0 = w_in_walk ? rob_idx(r_walk_ptr) : '0;
    assign walk_rd_addr1 = w_in_walk ? (rob_idx(r_walk_ptr) + ROB_IDX_W'(1)) : '0;

    // Same-lrd conflicts between slots are left for the spec RAT to resolve.
    assign walking_valid0 = w_slot0 && walk_rd_need_to_wb0;
    assign walking_valid1 = w_slot1 && walk_rd_need_to_wb1;
    assign walking_lrd0   = walking_valid0 ? walk_rd_lrd0 : '0;
    assign walking_lrd1   = walking_valid1 ? walk_rd_lrd1 : '0;
    assign walking_prd0   = walking_valid0 ? walk_rd_prd0 : '0;
    assign walking_prd1   = walking_valid1 ? walk_rd_prd1 : '0;

`ifdef RECOVERY_PERF_CNT_EN
    logic [31:0] r_perf_flush_cnt;
    logic [31:0] r_perf_recovery_cycles;

    // Saturating counters: accepted flushes (restarts included) and busy cycles.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_perf_flush_cnt       <= '0;
            r_perf_recovery_cycles <= '0;
        end else begin
            if (w_flush_acc && (r_perf_flush_cnt != '1)) begin
                r_perf_flush_cnt <= r_perf_flush_cnt + 32'd1;
            end
            if ((r_state != ROB_STATE_IDLE) && (r_perf_recovery_cycles != '1)) begin
                r_perf_recovery_cycles <= r_perf_recovery_cycles + 32'd1;
            end
        end
    end

    assign perf_flush_cnt       = r_perf_flush_cnt;
    assign perf_recovery_cycles = r_perf_recovery_cycles;
`endif

endmodule

// File: tb/tb_spec_rat_recovery_ctrl.sv
// Directed vector bench for spec_rat_recovery_ctrl.
// ROB model: entry i has lrd = i[4:0], prd = ~i, need_to_wb = (i != 4).
// Per-cycle table plus hand sequences for full-ROB walk and reset mid-recovery.
module tb_spec_rat_recovery_ctrl;

    localparam logic [1:0] S_I = 2'd0;
    localparam logic [1:0] S_R = 2'd1;
    localparam logic [1:0] S_W = 2'd2;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       flush_valid;
    logic [6:0] flush_ptr;
    logic       flush_incl_self;
    logic [6:0] rob_head_ptr;
    logic [5:0] walk_rd_addr0, walk_rd_addr1;
    logic       walk_rd_need_to_wb0, walk_rd_need_to_wb1;
    logic [4:0] walk_rd_lrd0, walk_rd_lrd1;
    logic [5:0] walk_rd_prd0, walk_rd_prd1;
    logic [1:0] rob_state;
    logic       walking_valid0, walking_valid1;
    logic [4:0] walking_lrd0, walking_lrd1;
    logic [5:0] walking_prd0, walking_prd1;
    logic       tail_restore_valid;
    logic [6:0] tail_restore_ptr;
    logic       rn_stall;
    logic       recovery_done;

    always #5 clock = ~clock;

    // Zero-latency ROB read model.
    assign walk_rd_need_to_wb0 = (walk_rd_addr0 != 6'd4);
    assign walk_rd_need_to_wb1 = (walk_rd_addr1 != 6'd4);
    assign walk_rd_lrd0        = walk_rd_addr0[4:0];
    assign walk_rd_lrd1        = walk_rd_addr1[4:0];
    assign walk_rd_prd0        = ~walk_rd_addr0;
    assign walk_rd_prd1        = ~walk_rd_addr1;

    spec_rat_recovery_ctrl dut (
        .clock               (clock),
        .reset_n             (reset_n),
        .flush_valid         (flush_valid),
        .flush_ptr           (flush_ptr),
        .flush_incl_self     (flush_incl_self),
        .rob_head_ptr        (rob_head_ptr),
        .walk_rd_addr0       (walk_rd_addr0),
        .walk_rd_addr1       (walk_rd_addr1),
        .walk_rd_need_to_wb0 (walk_rd_need_to_wb0),
        .walk_rd_need_to_wb1 (walk_rd_need_to_wb1),
        .walk_rd_lrd0        (walk_rd_lrd0),
        .walk_rd_lrd1        (walk_rd_lrd1),
        .walk_rd_prd0        (walk_rd_prd0),
        .walk_rd_prd1        (walk_rd_prd1),
        .rob_state           (rob_state),
        .walking_valid0      (walking_valid0),
        .walking_valid1      (walking_valid1),
        .walking_lrd0        (walking_lrd0),
        .walking_lrd1        (walking_lrd1),
        .walking_prd0        (walking_prd0),
        .walking_prd1        (walking_prd1),
        .tail_restore_valid  (tail_restore_valid),
        .tail_restore_ptr    (tail_restore_ptr),
        .rn_stall            (rn_stall),
        .recovery_done       (recovery_done)
    );

    typedef struct {
        logic       fv;
        logic [6:0] fp;
        logic       incl;
        logic [6:0] head;
        logic [1:0] st;
        logic       v0;
        logic       v1;
        logic [5:0] a0;
        logic [5:0] a1;
        logic       done;
        logic       tv;
        logic [6:0] tp;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    function automatic vec_t mk(logic fv, logic [6:0] fp, logic incl, logic [6:0] head,
                                logic [1:0] st, logic v0, logic v1, logic [5:0] a0,
                                logic [5:0] a1, logic done, logic tv, logic [6:0] tp);
        vec_t v;
        v.fv = fv; v.fp = fp; v.incl = incl; v.head = head;
        v.st = st; v.v0 = v0; v.v1 = v1; v.a0 = a0; v.a1 = a1;
        v.done = done; v.tv = tv; v.tp = tp;
        return v;
    endfunction

    // No flush this cycle, expect IDLE with quiet outputs.
    function automatic vec_t idle_row();
        return mk(1'b0, 7'd0, 1'b0, 7'd0, S_I, 1'b0, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 7'd0);
    endfunction

    // Flush request this cycle (DUT still IDLE while it is presented).
    function automatic vec_t flush_row(logic [6:0] fp, logic incl, logic [6:0] head);
        return mk(1'b1, fp, incl, head, S_I, 1'b0, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 7'd0);
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic fv, input logic [6:0] fp, input logic incl, input logic [6:0] head);
        flush_valid     = fv;
        flush_ptr       = fp;
        flush_incl_self = incl;
        rob_head_ptr    = head;
    endtask

    task automatic check_row(input vec_t v, input int i);
        logic [4:0] el0, el1;
        logic [5:0] ep0, ep1;
        el0 = v.v0 ? v.a0[4:0] : 5'd0;
        el1 = v.v1 ? v.a1[4:0] : 5'd0;
        ep0 = v.v0 ? ~v.a0 : 6'd0;
        ep1 = v.v1 ? ~v.a1 : 6'd0;
        check($sformatf("row%0d state", i), 32'(rob_state), 32'(v.st));
        check($sformatf("row%0d rn_stall", i), 32'(rn_stall), 32'(v.st != S_I));
        check($sformatf("row%0d wvalid0", i), 32'(walking_valid0), 32'(v.v0));
        check($sformatf("row%0d wvalid1", i), 32'(walking_valid1), 32'(v.v1));
        check($sformatf("row%0d wlrd0", i), 32'(walking_lrd0), 32'(el0));
        check($sformatf("row%0d wlrd1", i), 32'(walking_lrd1), 32'(el1));
        check($sformatf("row%0d wprd0", i), 32'(walking_prd0), 32'(ep0));
        check($sformatf("row%0d wprd1", i), 32'(walking_prd1), 32'(ep1));
        check($sformatf("row%0d done", i), 32'(recovery_done), 32'(v.done));
        check($sformatf("row%0d tail_vld", i), 32'(tail_restore_valid), 32'(v.tv));
        if (v.tv) check($sformatf("row%0d tail_ptr", i), 32'(tail_restore_ptr), 32'(v.tp));
        if (v.st == S_W) begin
            check($sformatf("row%0d addr0", i), 32'(walk_rd_addr0), 32'(v.a0));
            check($sformatf("row%0d addr1", i), 32'(walk_rd_addr1), 32'(v.a1));
        end
    endtask

    initial begin
        int walk_cycles;
        int done_in_walk;
        int ended;

        drive(1'b0, 7'd0, 1'b0, 7'd0);

        // Idle after reset.
        repeat (5) vecs.push_back(idle_row());
        // Head 3, mispredict at 7: walk {3,4(no wb)}, {5,6}, {7}.
        vecs.push_back(flush_row(7'd7, 1'b1, 7'd3));
        vecs.push_back(mk(1'b0, 7'd0, 1'b0, 7'd0, S_R, 1'b0, 1'b0, 6'd0, 6'd0, 1'b0, 1'b1, 7'd8));
        vecs.push_back(mk(1'b0, 7'd0, 1'b0, 7'd0, S_W, 1'b1, 1'b0, 6'd3, 6'd4, 1'b0, 1'b0, 7'd0));
        vecs.push_back(mk(1'b0, 7'd0, 1'b0, 7'd0, S_W, 1'b1, 1'b1, 6'd5, 6'd6, 1'b0, 1'b0, 7'd0));
        vecs.push_back(mk(1'b0, 7'd0, 1'b0, 7'd0, S_W, 1'b1, 1'b0, 6'd7, 6'd8, 1'b1, 1'b0, 7'd0));
        vecs.push_back(idle_row());
        // Exception at the head: ROLLBACK straight back to IDLE.
        vecs.push_back(flush_row(7'd5, 1'b0, 7'd5));
        vecs.push_back(mk(1'b0, 7'd0, 1'b0, 7'd0, S_R, 1'b0, 1'b0, 6'd0, 6'd0, 1'b1, 1'b1, 7'd5));
        vecs.push_back(idle_row());
        // Wrap across ROB end: 62,63,0,1; new tail has wrap bit set.
        vecs.push_back(flush_row(7'h41, 1'b1, 7'h3E));
        vecs.push_back(mk(1'b0, 7'd0, 1'b0, 7'd0, S_R, 1'b0, 1'b0, 6'd0, 6'd0, 1'b0, 1'b1, 7'h42));
        vecs.push_back(mk(1'b0, 7'd0, 1'b0, 7'd0, S_W, 1'b1, 1'b1, 6'd62, 6'd63, 1'b0, 1'b0, 7'd0));
        vecs.push_back(mk(1'b0, 7'd0, 1'b0, 7'd0, S_W, 1'b1, 1'b1, 6'd0, 6'd1, 1'b1, 1'b0, 7'd0));
        vecs.push_back(idle_row());
        // Head 0, end 20; older flush 9 restarts, younger flush 15 ignored.
        vecs.push_back(flush_row(7'd19, 1'b1, 7'd0));
        vecs.push_back(mk(1'b0, 7'd0, 1'b0, 7'd0, S_R, 1'b0, 1'b0, 6'd0, 6'd0, 1'b0, 1'b1, 7'd20));
        vecs.push_back(mk(1'b0, 7'd0, 1'b0, 7'd0, S_W, 1'b1, 1'b1, 6'd0, 6'd1, 1'b0, 1'b0, 7'd0));
        vecs.push_back(mk(1'b1, 7'd9, 1'b1, 7'd0, S_W, 1'b1, 1'b1, 6'd2, 6'd3, 1'b0, 1'b0, 7'd0));
        vecs.push_back(mk(1'b0, 7'd0, 1'b0, 7'd0, S_R, 1'b0, 1'b0, 6'd0, 6'd0, 1'b0, 1'b1, 7'd10));
        vecs.push_back(mk(1'b1, 7'd15, 1'b1, 7'd0, S_W, 1'b1, 1'b1, 6'd0, 6'd1, 1'b0, 1'b0, 7'd0));
        vecs.push_back(mk(1'b0, 7'd0, 1'b0, 7'd0, S_W, 1'b1, 1'b1, 6'd2, 6'd3, 1'b0, 1'b0, 7'd0));
        vecs.push_back(mk(1'b0, 7'd0, 1'b0, 7'd0, S_W, 1'b0, 1'b1, 6'd4, 6'd5, 1'b0, 1'b0, 7'd0));
        vecs.push_back(mk(1'b0, 7'd0, 1'b0, 7'd0, S_W, 1'b1, 1'b1, 6'd6, 6'd7, 1'b0, 1'b0, 7'd0));
        vecs.push_back(mk(1'b0, 7'd0, 1'b0, 7'd0, S_W, 1'b1, 1'b1, 6'd8, 6'd9, 1'b1, 1'b0, 7'd0));
        vecs.push_back(idle_row());
        vecs.push_back(idle_row());

        // Reset values.
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset state", 32'(rob_state), 32'd0);
        check("reset rn_stall", 32'(rn_stall), 32'd0);
        check("reset wvalid0", 32'(walking_valid0), 32'd0);
        check("reset wvalid1", 32'(walking_valid1), 32'd0);
        check("reset done", 32'(recovery_done), 32'd0);
        check("reset tail_vld", 32'(tail_restore_valid), 32'd0);
        check("reset tail_ptr", 32'(tail_restore_ptr), 32'd0);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            @(posedge clock);
            #1 drive(vecs[i].fv, vecs[i].fp, vecs[i].incl, vecs[i].head);
            @(negedge clock);
            check_row(vecs[i], i);
        end

        // Full ROB: head 0x10, boundary 0x50 (64 entries) -> 32 WALK cycles.
        @(posedge clock);
        #1 drive(1'b1, 7'h4F, 1'b1, 7'h10);
        @(posedge clock);
        #1 drive(1'b0, 7'd0, 1'b0, 7'd0);
        walk_cycles  = 0;
        done_in_walk = 0;
        ended        = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clock);
            if (rob_state == S_W) begin
                walk_cycles++;
                if (recovery_done) done_in_walk++;
            end
            if (rob_state == S_I) begin
                ended = 1;
                break;
            end
        end
        check("full ended", 32'(ended), 32'd1);
        check("full walk_cycles", 32'(walk_cycles), 32'd32);
        check("full done_count", 32'(done_in_walk), 32'd1);

        // Reset in the middle of a walk: immediate IDLE, no done pulse.
        @(posedge clock);
        #1 drive(1'b1, 7'd30, 1'b1, 7'd0);
        @(posedge clock);
        #1 drive(1'b0, 7'd0, 1'b0, 7'd0);
        @(posedge clock);
        @(negedge clock);
        check("midrst pre state", 32'(rob_state), 32'(S_W));
        #2 reset_n = 1'b0;
        #1;
        check("midrst state", 32'(rob_state), 32'd0);
        check("midrst rn_stall", 32'(rn_stall), 32'd0);
        check("midrst wvalid0", 32'(walking_valid0), 32'd0);
        check("midrst wvalid1", 32'(walking_valid1), 32'd0);
        check("midrst done", 32'(recovery_done), 32'd0);
        check("midrst tail_ptr", 32'(tail_restore_ptr), 32'd0);
        @(posedge clock);
        #1 reset_n = 1'b1;
        @(negedge clock);
        check("postrst state", 32'(rob_state), 32'd0);
        check("postrst done", 32'(recovery_done), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/spec_rat_recovery_ctrl.md
Name: spec_rat_recovery_ctrl

Overview:
Sequences recovery of the speculative RAT after a redirect (branch mispredict or exception). On an accepted flush it drives one ROLLBACK cycle, during which the spec RAT copies the arch RAT. It then walks the surviving ROB entries from the latched head up to the flush boundary, replaying up to two lrd->prd mappings per cycle onto the spec RAT walk port. It owns rob_state and stalls rename until recovery is complete.

Parameters:
ROB_IDX_W, 6, ROB index width (ROB_DEPTH = 2**ROB_IDX_W = 64)
PTR_W, 7, ROB pointer width: index plus wrap bit
PREG_W, 6, physical register tag width
LREG_W, 5, logical register index width

Ports:
clock  in  1  clock
reset_n  in  1  async active-low reset
flush_valid  in  1  redirect request, single-cycle pulse
flush_ptr  in  PTR_W  ROB pointer of the redirecting instruction
flush_incl_self  in  1  1 = mispredict (replay the flush instr itself); 0 = exception (do not replay it)
rob_head_ptr  in  PTR_W  current ROB head; commit is frozen while rob_state != IDLE
walk_rd_addr0/1  out  ROB_IDX_W  combinational ROB read addresses (walk_ptr, walk_ptr+1)
walk_rd_need_to_wb0/1  in  1  entry writes a destination (same-cycle data)
walk_rd_lrd0/1  in  LREG_W  entry lrd
walk_rd_prd0/1  in  PREG_W  entry prd
rob_state  out  2  IDLE=2'b00, ROLLBACK=2'b01, WALK=2'b10
walking_valid0/1  out  1  walk write enables to spec RAT
walking_lrd0/1  out  LREG_W  walk logical destination
walking_prd0/1  out  PREG_W  walk physical destination
tail_restore_valid  out  1  1-cycle pulse: ROB tail <= tail_restore_ptr
tail_restore_ptr  out  PTR_W  new ROB tail = walk end pointer
rn_stall  out  1  rename stall; equals (rob_state != IDLE)
recovery_done  out  1  1-cycle pulse on the WALK->IDLE or ROLLBACK->IDLE transition

Behaviour:
- Reset values: state IDLE; all outputs 0; walk_ptr = 0; end_ptr = 0.
- Flush accept, from IDLE:
  - end_ptr <= flush_ptr + flush_incl_self (PTR_W modular arithmetic; wrap bit toggles across depth).
  - walk_ptr <= rob_head_ptr.
  - Next state: ROLLBACK.
  - tail_restore_valid pulses in the cycle after accept, with tail_restore_ptr = end_ptr.
- ROLLBACK: lasts exactly 1 cycle; walking_valid* = 0.
  - remaining = end_ptr - walk_ptr (PTR_W modular).
  - remaining == 0 -> IDLE, recovery_done pulses.
  - remaining != 0 -> WALK.
- WALK, each cycle: remaining = end_ptr - walk_ptr.
  - Slot0 is active if remaining >= 1; slot1 is active if remaining >= 2.
  - walking_valid_k = slot_k active AND walk_rd_need_to_wb_k.
  - walking_lrd/prd_k mirror the ROB read data. They are 0 when walking_valid_k = 0.
  - walk_ptr advances by the number of active slots.
  - Exit when remaining <= 2: WALK -> IDLE, and recovery_done asserts on the final walk cycle.
- Walk outputs are combinational from the ROB read data (zero-latency ROB read).
- Same-lrd slot ordering is resolved downstream (slot1 wins); this block does not filter it.
- Flush while ROLLBACK/WALK:
  - Accepted only if older than the current boundary: (flush_ptr - head_lat) < (end_ptr - 1 - head_lat), where head_lat is the latched head.
  - An older flush reloads end_ptr, resets walk_ptr to head_lat, re-enters ROLLBACK and re-pulses tail_restore.
  - A younger flush, or one equal to the boundary, is ignored.
- Full ROB (end_ptr - head = 64): legal; the walk takes 32 WALK cycles.
- Wrap: index = ptr[ROB_IDX_W-1:0]; walk_rd_addr1 wraps modulo ROB_DEPTH.
- Reset mid-recovery: immediate IDLE, all outputs 0, no recovery_done pulse.

Optional Feature:
RECOVERY_PERF_CNT_EN
- Defined: adds 32-bit outputs perf_flush_cnt (accepted flushes, including restarts) and perf_recovery_cycles (cycles with rob_state != IDLE).
  - Both saturate at all-ones and reset to 0.
- Undefined: the ports and counters are absent; no other behaviour changes.

Decomposition:
- The shared defines header holds ROB_STATE_IDLE/ROLLBACK/WALK, PREG_RANGE, LREG_RANGE and the ROB pointer width constant. rob and spec RAT already consume these.
- One sub-module, rob_ptr_dist: wrap-aware pointer subtraction plus the age compare. It is instantiated twice (remaining count and older-flush check).

Test Plan:
- Reset, then idle 5 cycles -> rob_state=0, rn_stall=0, all walking_valid=0.
- Head=3, flush_ptr=7, incl_self=1 -> ROLLBACK 1 cycle, then WALK 3 cycles with entries {3,4},{5,6},{7 only}; recovery_done on the 3rd WALK cycle; tail_restore_ptr=8.
- Head=5, flush_ptr=5, incl_self=0 -> ROLLBACK then straight to IDLE; no walking_valid; tail_restore_ptr=5.
- Wrap: head=7'h3E, flush_ptr=7'h41, incl_self=1 -> walk addresses 62,63,0,1; tail_restore_ptr=7'h42; wrap bit set.
- Entries with need_to_wb=0 at idx 4 -> slot skipped (walking_valid=0) but walk_ptr still advances; idle cycle count is unchanged.
- During WALK (head=0, end=20) inject flush_ptr=9, incl_self=1 -> re-enter ROLLBACK, end=10, walk restarts at 0. A subsequent flush_ptr=15 is ignored.
